// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word addresses to a 1-cycle
// instruction memory, holds the current word under stall, applies redirects.
// Ports: clk, rst (async, active-high); imem_addr/imem_rdata memory side;
//   stall, redirect_valid, redirect_pc from downstream; inst_valid, inst,
//   inst_pc, misalign (sticky), fetch_count (accepted instructions).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        resp_valid_q;
  logic [31:0] resp_pc_q;
  logic [31:0] hold_q;
  logic [31:0] hold_pc_q;
  logic        misalign_q;
  logic [31:0] count_q;

  logic [31:0] redir_pc;
  logic        accept;
  logic        run_adv;
  logic        run_hold;
  logic        hold_rel;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  // The memory sees the redirect target in the same cycle, so the
  // target word is on imem_rdata one cycle later.
  assign imem_addr = rst            ? RESET_PC :
                     redirect_valid ? redir_pc : pc_q;

  always_comb begin
    inst_valid = 1'b0;
    inst       = imem_rdata;
    inst_pc    = resp_pc_q;
    if (state_q == HOLD) begin
      inst_valid = !redirect_valid;
      inst       = hold_q;
      inst_pc    = hold_pc_q;
    end else begin
      inst_valid = resp_valid_q && !redirect_valid;
    end
  end

  assign accept = inst_valid && !stall;

  assign run_adv  = (state_q == RUN) && !redirect_valid &&
                    (!stall || !resp_valid_q);
  assign run_hold = (state_q == RUN) && !redirect_valid &&
                    stall && resp_valid_q;
  assign hold_rel = (state_q == HOLD) && !redirect_valid && !stall;

  assign misalign    = misalign_q;
  assign fetch_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      hold_q       <= NOP_INSN;
      hold_pc_q    <= RESET_PC;
      misalign_q   <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      if (accept)
        count_q <= count_q + 32'd1;
      unique case (1'b1)
        redirect_valid: begin
          state_q      <= RUN;
          resp_valid_q <= 1'b1;
          resp_pc_q    <= redir_pc;
          pc_q         <= redir_pc + 32'd4;
          if (redirect_pc[1:0] != 2'b00)
            misalign_q <= 1'b1;
        end
        run_adv, hold_rel: begin
          state_q      <= RUN;
          resp_valid_q <= 1'b1;
          resp_pc_q    <= pc_q;
          pc_q         <= pc_q + 32'd4;
        end
        run_hold: begin
          // Capture the word now, because the memory moves on next edge.
          state_q      <= HOLD;
          hold_q       <= imem_rdata;
          hold_pc_q    <= resp_pc_q;
          resp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (default and wrap-around reset PC)
// against an instruction-stream reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  logic [31:0] ia [2];
  logic [31:0] rd [2];
  logic        iv [2];
  logic [31:0] ins [2];
  logic [31:0] ip [2];
  logic        mis [2];
  logic [31:0] fc [2];

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  fetch_unit u0 (
    .clk(clk), .rst(rst), .imem_addr(ia[0]), .imem_rdata(rd[0]),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(iv[0]), .inst(ins[0]),
    .inst_pc(ip[0]), .misalign(mis[0]), .fetch_count(fc[0])
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .imem_addr(ia[1]), .imem_rdata(rd[1]),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(iv[1]), .inst(ins[1]),
    .inst_pc(ip[1]), .misalign(mis[1]), .fetch_count(fc[1])
  );

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return 32'h0000_0093 + (k << 20);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      rd[i] <= rst ? NOP : mword(ia[i]);
  end

  // Reference: the instruction stream as seen by decode.
  logic        m_valid [2];
  logic [31:0] m_cur [2];
  logic [31:0] m_nxt [2];
  logic [31:0] m_cnt [2];
  logic        m_mis [2];

  function automatic logic [31:0] rpc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic mreset(input int i);
    m_valid[i] = 1'b0;
    m_cur[i]   = rpc(i);
    m_nxt[i]   = rpc(i);
    m_cnt[i]   = 32'd0;
    m_mis[i]   = 1'b0;
  endtask

  task automatic step(input logic s, input logic rv,
                      input logic [31:0] rp, input logic r);
    logic        ev;
    logic [31:0] tgt;
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    rst            = r;
    tgt            = rp & 32'hFFFF_FFFC;
    if (r)
      for (int i = 0; i < 2; i++) mreset(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = m_valid[i] && !rv && !r;
      chk($sformatf("u%0d.inst_valid", i), {31'd0, iv[i]}, {31'd0, ev});
      if (ev) begin
        chk($sformatf("u%0d.inst_pc", i), ip[i], m_cur[i]);
        chk($sformatf("u%0d.inst", i), ins[i], mword(m_cur[i]));
      end
      chk($sformatf("u%0d.imem_addr", i), ia[i],
          r ? rpc(i) : (rv ? tgt : m_nxt[i]));
      chk($sformatf("u%0d.fetch_count", i), fc[i], m_cnt[i]);
      chk($sformatf("u%0d.misalign", i), {31'd0, mis[i]},
          {31'd0, m_mis[i]});
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i] && !rv && !s)
          m_cnt[i] = m_cnt[i] + 32'd1;
        if (rv) begin
          m_valid[i] = 1'b1;
          m_cur[i]   = tgt;
          m_nxt[i]   = tgt + 32'd4;
          if (rp[1:0] != 2'b00) m_mis[i] = 1'b1;
        end else if (!(m_valid[i] && s)) begin
          m_valid[i] = 1'b1;
          m_cur[i]   = m_nxt[i];
          m_nxt[i]   = m_nxt[i] + 32'd4;
        end
      end
    end
  endtask

  initial begin
    logic        s, rv, r;
    logic [31:0] rp;
    for (int i = 0; i < 2; i++) mreset(i);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // Sequential fetch from reset: bubble, then pc 0, 4.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Hold pc 8 for three cycles, then continue without a bubble.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Redirect while pc 12 is presented.
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Redirect during hold.
    step(1, 0, 0, 0);
    step(1, 1, 32'h80, 0);
    step(0, 0, 0, 0);
    // Misaligned target, sticky flag, then cleared by reset.
    step(0, 1, 32'h42, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reset mid-hold.
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      s  = ($urandom % 10) < 3;
      rv = ($urandom % 10) == 0;
      r  = ($urandom % 80) == 0;
      if ($urandom % 2 == 0)
        rp = 32'hFFFF_FFF0 | ($urandom % 16);
      else
        rp = $urandom;
      step(s, rv, rp, r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
